cpu_skid_stage: RTL

Two-entry registered pipeline stage that sits between a producing and a consuming CPU pipeline stage. It accepts data from upstream under a valid/busy handshake and presents it downstream. Upstream backpressure (`o_busy`) is driven purely from registered state. This breaks the combinational stall path that a single-register hold buffer leaves open from the downstream `i_busy` back to the producer.

---
 rtl/cpu_skid_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/cpu_skid_stage.sv
// Two-entry skid buffer between CPU pipeline stages. Upstream backpressure is
// decoded from registered occupancy, so the downstream stall never reaches o_busy combinationally.
module cpu_skid_stage #(
  parameter int DW = 32
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_busy,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_busy,
  output logic [1:0]    o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [DW-1:0] main_r;
  logic [DW-1:0] main_s;
  logic [DW-1:0] skid_r;
  logic [DW-1:0] skid_s;
  logic          valid_r;
  logic          busy_r;
  logic [1:0]    count_r;
  logic          acc_s;
  logic          con_s;

  assign acc_s   = i_valid & ~busy_r;
  assign con_s   = valid_r & ~i_busy;
  assign o_busy  = busy_r;
  assign o_valid = valid_r;
  assign o_count = count_r;
  assign o_data  = main_r;

  // Next-state and storage update; flush overrides every transition.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    if (i_flush) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (acc_s) begin
            state_s = ONE;
            main_s  = i_data;
          end else begin
            state_s = EMPTY;
          end
        end
        ONE: begin
          if (acc_s && con_s) begin
            state_s = ONE;
            main_s  = i_data;
          end else if (acc_s) begin
            state_s = FULL;
            skid_s  = i_data;
          end else if (con_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        FULL: begin
          if (con_s) begin
            state_s = ONE;
            main_s  = skid_r;
          end else begin
            state_s = FULL;
          end
        end
        default: begin
          state_s = EMPTY;
        end
      endcase
    end
  end

  // State, storage and output flags, all decoded from the next state so they stay registered.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= EMPTY;
      main_r  <= {DW{1'b0}};
      skid_r  <= {DW{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      state_r <= state_s;
      main_r  <= main_s;
      skid_r  <= skid_s;
      valid_r <= (state_s != EMPTY);
      busy_r  <= (state_s == FULL);
      case (state_s)
        EMPTY:   count_r <= 2'd0;
        ONE:     count_r <= 2'd1;
        FULL:    count_r <= 2'd2;
        default: count_r <= 2'd0;
      endcase
    end
  end

endmodule
